// File: rtl/funrv32_alu_pkg.sv
// Shared ALU definitions: opsel codes, widths, delay-line entry and op decode.
// Used by main_alu and by its checker so both agree on the encoding.
// Opsel is {funct7[5], funct3}; codes not listed here are unchecked.
package funrv32_alu_pkg;

    localparam int XLEN    = 32;
    localparam int OPSEL_W = 4;

    localparam logic [OPSEL_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPSEL_W-1:0] OP_SUB  = 4'b1000;
    localparam logic [OPSEL_W-1:0] OP_SLL  = 4'b0001;
    localparam logic [OPSEL_W-1:0] OP_SLT  = 4'b0010;
    localparam logic [OPSEL_W-1:0] OP_SLTU = 4'b0011;
    localparam logic [OPSEL_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OPSEL_W-1:0] OP_SRL  = 4'b0101;
    localparam logic [OPSEL_W-1:0] OP_SRA  = 4'b1101;
    localparam logic [OPSEL_W-1:0] OP_OR   = 4'b0110;
    localparam logic [OPSEL_W-1:0] OP_AND  = 4'b0111;

    // One slot of the checker's expectation delay line.
    typedef struct packed {
        logic                vld;
        logic                skip;
        logic [OPSEL_W-1:0]  opsel;
        logic [XLEN-1:0]     exp;
    } chk_entry_t;

    function automatic logic is_defined_op(input logic [OPSEL_W-1:0] opsel);
        case (opsel)
            OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
            OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: is_defined_op = 1'b1;
            default:                               is_defined_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Golden ALU model: combinational result for one operand/opsel set.
// Latency: zero (pure combinational).
// No flow control; o_defined flags opsel codes that have a checked result.
module alu_ref_model
    import funrv32_alu_pkg::*;
(
    input  logic [XLEN-1:0]    i_op1,
    input  logic [XLEN-1:0]    i_op2,
    input  logic [OPSEL_W-1:0] i_opsel,
    output logic [XLEN-1:0]    o_result,
    output logic               o_defined
);

    logic [4:0] shamt;

    // Evaluate the selected operation; undefined codes yield zero.
    always_comb begin
        shamt     = i_op2[4:0];
        o_defined = is_defined_op(i_opsel);
        case (i_opsel)
            OP_ADD:  o_result = i_op1 + i_op2;
            OP_SUB:  o_result = i_op1 - i_op2;
            OP_SLL:  o_result = i_op1 << shamt;
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            OP_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_op1 < i_op2)};
            OP_XOR:  o_result = i_op1 ^ i_op2;
            OP_SRL:  o_result = i_op1 >> shamt;
            OP_SRA:  o_result = XLEN'($signed(i_op1) >>> shamt);
            OP_OR:   o_result = i_op1 | i_op2;
            OP_AND:  o_result = i_op1 & i_op2;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/main_alu_checker.sv
// ALU response checker: delays golden results, compares with i_aluout, counts.
// Latency: compare LATENCY cycles after issue, counters update on the next edge.
// No backpressure: accepts an issue every cycle; i_clear/i_rst flush in-flight work.
module main_alu_checker
    import funrv32_alu_pkg::*;
#(
    parameter int LATENCY      = 1,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic [XLEN-1:0]     i_op1,
    input  logic [XLEN-1:0]     i_op2,
    input  logic [OPSEL_W-1:0]  i_opsel,
    input  logic [XLEN-1:0]     i_aluout,
    input  logic                i_clear,
    output logic [CNT_W-1:0]    o_pass_cnt,
    output logic [CNT_W-1:0]    o_fail_cnt,
    output logic                o_error,
    output logic                o_halted,
    output logic [OPSEL_W-1:0]  o_err_opsel,
    output logic [XLEN-1:0]     o_err_expected,
    output logic [XLEN-1:0]     o_err_actual
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      state;
    chk_entry_t      pipe [LATENCY];
    chk_entry_t      stage_in;
    chk_entry_t      stage_out;
    logic [XLEN-1:0] golden;
    logic            defined;
    logic            cmp_en;
    logic            mismatch;

    alu_ref_model u_ref (
        .i_op1     (i_op1),
        .i_op2     (i_op2),
        .i_opsel   (i_opsel),
        .o_result  (golden),
        .o_defined (defined)
    );

    // Build the entry for this cycle's issue and evaluate the oldest entry.
    always_comb begin
        stage_in.vld   = i_valid;
        stage_in.skip  = ~defined;
        stage_in.opsel = i_opsel;
        stage_in.exp   = golden;
        stage_out      = pipe[LATENCY-1];
        cmp_en         = (state == ST_RUN) && stage_out.vld && !stage_out.skip;
        mismatch       = (stage_out.exp != i_aluout);
    end

    assign o_halted = (state == ST_HALT);

    // Delay line, counters, first-error capture and RUN/HALT state.
    // Clear and reset both flush the delay line, including this cycle's issue.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            for (int k = 0; k < LATENCY; k++) begin
                pipe[k] <= '0;
            end
            state          <= ST_RUN;
            o_pass_cnt     <= '0;
            o_fail_cnt     <= '0;
            o_error        <= 1'b0;
            o_err_opsel    <= '0;
            o_err_expected <= '0;
            o_err_actual   <= '0;
        end else begin
            pipe[0] <= stage_in;
            for (int k = 1; k < LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
            if (cmp_en) begin
                if (!mismatch) begin
                    if (o_pass_cnt != '1) begin
                        o_pass_cnt <= o_pass_cnt + CNT_W'(1);
                    end
                end else begin
                    if (o_fail_cnt != '1) begin
                        o_fail_cnt <= o_fail_cnt + CNT_W'(1);
                    end
                    // Only the first mismatch is kept for post-mortem.
                    if (!o_error) begin
                        o_error        <= 1'b1;
                        o_err_opsel    <= stage_out.opsel;
                        o_err_expected <= stage_out.exp;
                        o_err_actual   <= i_aluout;
                    end
                    if (STOP_ON_FAIL) begin
                        state <= ST_HALT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_main_alu_checker.sv
// Directed bench for main_alu_checker: table of vectors plus corner sequences.
// Two instances: default (LATENCY=1, CNT_W=16, halting) and a small-counter one.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_main_alu_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Default instance signals
    logic        rst, valid, clr;
    logic [31:0] op1, op2, aluout;
    logic [3:0]  opsel;
    logic [15:0] pass_cnt, fail_cnt;
    logic        error, halted;
    logic [3:0]  err_opsel;
    logic [31:0] err_expected, err_actual;

    // Small-counter instance signals
    logic        v4, c4;
    logic [31:0] a4, b4, r4;
    logic [3:0]  s4;
    logic [3:0]  pass4, fail4;
    logic        error4, halted4;
    logic [3:0]  err_opsel4;
    logic [31:0] err_exp4, err_act4;

    main_alu_checker dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_op1(op1), .i_op2(op2),
        .i_opsel(opsel), .i_aluout(aluout), .i_clear(clr),
        .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt), .o_error(error),
        .o_halted(halted), .o_err_opsel(err_opsel),
        .o_err_expected(err_expected), .o_err_actual(err_actual)
    );

    main_alu_checker #(.LATENCY(2), .CNT_W(4), .STOP_ON_FAIL(1'b0)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_op1(a4), .i_op2(b4),
        .i_opsel(s4), .i_aluout(r4), .i_clear(c4),
        .o_pass_cnt(pass4), .o_fail_cnt(fail4), .o_error(error4),
        .o_halted(halted4), .o_err_opsel(err_opsel4),
        .o_err_expected(err_exp4), .o_err_actual(err_act4)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opsel;
        logic [31:0] aluout;
        int          exp_pass;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                       input logic [31:0] r, input int ep);
        vec_t v;
        v.op1 = a; v.op2 = b; v.opsel = s; v.aluout = r; v.exp_pass = ep;
        tbl.push_back(v);
    endtask

    // Independent behavioural ALU used to drive the sweep's aluout.
    function automatic logic [31:0] tb_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] s);
        logic [4:0]  sh;
        logic [31:0] ones;
        sh   = b[4:0];
        ones = 32'hFFFF_FFFF;
        case (s)
            4'b0000: return a + b;
            4'b1000: return a + ~b + 32'd1;
            4'b0001: return a << sh;
            4'b0010: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'b0011: return {31'd0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return a[31] ? ((a >> sh) | ~(ones >> sh)) : (a >> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] sw1, sw2, prev_exp;
        logic [3:0]  sws;

        // Hand-computed vectors; exp_pass is the cumulative pass count after compare.
        add(32'd5,         32'd7,         4'b0000, 32'd12,        1);
        add(32'd5,         32'd7,         4'b1000, 32'hFFFF_FFFE, 2);
        add(32'd1,         32'h21,        4'b0001, 32'd2,         3);
        add(32'hFFFF_FFFF, 32'd1,         4'b0010, 32'd1,         4);
        add(32'hFFFF_FFFF, 32'd1,         4'b0011, 32'd0,         5);
        add(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 32'h0FF0_0FF0, 6);
        add(32'h8000_0000, 32'd4,         4'b0101, 32'h0800_0000, 7);
        add(32'h1234_0000, 32'h0000_5678, 4'b0110, 32'h1234_5678, 8);
        add(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0111, 32'h0F0F_0000, 9);
        add(32'd1,         32'd2,         4'b1111, 32'hDEAD_BEEF, 9);
        add(32'd3,         32'd4,         4'b1111, 32'h0,         9);
        add(32'd5,         32'd6,         4'b1111, 32'h1,         9);
        add(32'd1,         32'd1,         4'b1001, 32'h5,         9);
        add(32'd1,         32'd1,         4'b1010, 32'h6,         9);
        add(32'd1,         32'd1,         4'b1011, 32'h7,         9);
        add(32'd1,         32'd1,         4'b1100, 32'h8,         9);
        add(32'd1,         32'd1,         4'b1110, 32'h9,         9);
        add(32'hFFFF_FFFF, 32'd1,         4'b0000, 32'd0,         10);
        add(32'h8000_0000, 32'h24,        4'b1101, 32'hF800_0000, 11);

        rst = 1'b1; valid = 0; clr = 0; op1 = 0; op2 = 0; opsel = 0; aluout = 0;
        v4 = 0; c4 = 0; a4 = 0; b4 = 0; s4 = 0; r4 = 0;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();

        // Reset state
        chk("rst_pass", 32'(pass_cnt), 0);
        chk("rst_fail", 32'(fail_cnt), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err_opsel", 32'(err_opsel), 0);
        chk("rst_err_exp", err_expected, 0);
        chk("rst_err_act", err_actual, 0);
        chk("rst4_pass", 32'(pass4), 0);
        chk("rst4_halted", 32'(halted4), 0);

        // Table: back-to-back issue, aluout for the previous vector each cycle
        for (int i = 0; i <= tbl.size(); i++) begin
            valid = (i < tbl.size());
            if (i < tbl.size()) begin
                op1 = tbl[i].op1; op2 = tbl[i].op2; opsel = tbl[i].opsel;
            end
            aluout = (i > 0) ? tbl[i-1].aluout : 32'h0;
            tick();
            if (i > 0) begin
                chk($sformatf("tbl%0d_pass", i-1), 32'(pass_cnt), 32'(tbl[i-1].exp_pass));
                chk($sformatf("tbl%0d_fail", i-1), 32'(fail_cnt), 0);
            end
        end
        valid = 0;

        // SRA mismatch halts and captures the first error
        op1 = 32'h8000_0000; op2 = 32'd4; opsel = 4'b1101; valid = 1; aluout = 0;
        tick();
        valid = 0; aluout = 32'h0800_0000;
        tick();
        chk("sra_fail", 32'(fail_cnt), 1);
        chk("sra_error", 32'(error), 1);
        chk("sra_halted", 32'(halted), 1);
        chk("sra_err_opsel", 32'(err_opsel), 32'hD);
        chk("sra_err_exp", err_expected, 32'hF800_0000);
        chk("sra_err_act", err_actual, 32'h0800_0000);
        chk("sra_pass", 32'(pass_cnt), 11);

        // Ten good vectors while halted: everything frozen
        for (int j = 0; j <= 10; j++) begin
            valid = (j < 10); op1 = 32'(j); op2 = 32'(j); opsel = 4'b0000;
            aluout = (j > 0) ? 32'((j - 1) * 2) : 32'h0;
            tick();
        end
        valid = 0;
        chk("halt_pass", 32'(pass_cnt), 11);
        chk("halt_fail", 32'(fail_cnt), 1);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_err_act", err_actual, 32'h0800_0000);

        // Clear with a vector issued in the same cycle: that vector is dropped
        clr = 1; valid = 1; op1 = 1; op2 = 1; opsel = 4'b0000; aluout = 0;
        tick();
        clr = 0; valid = 0; aluout = 32'hBAD0_BAD0;
        chk("clr_pass", 32'(pass_cnt), 0);
        chk("clr_fail", 32'(fail_cnt), 0);
        chk("clr_error", 32'(error), 0);
        chk("clr_halted", 32'(halted), 0);
        chk("clr_err_exp", err_expected, 0);
        tick();
        chk("clr_drop_fail", 32'(fail_cnt), 0);
        chk("clr_drop_pass", 32'(pass_cnt), 0);

        // Standard sweep, 64 back-to-back issues with a behavioural ALU
        sw1 = 32'h0; sw2 = 32'hFFFF_FFFF; sws = 4'h0; prev_exp = 32'h0;
        for (int k = 0; k <= 64; k++) begin
            valid = (k < 64); op1 = sw1; op2 = sw2; opsel = sws;
            aluout = prev_exp;
            prev_exp = tb_alu(sw1, sw2, sws);
            tick();
            sw1 = sw1 + 32'h0001_0000; sw2 = sw2 + 32'h0010_0000; sws = sws + 4'd1;
        end
        valid = 0;
        chk("sweep_pass", 32'(pass_cnt), 40);
        chk("sweep_fail", 32'(fail_cnt), 0);
        chk("sweep_error", 32'(error), 0);

        // Small counters, LATENCY=2: saturation at 15
        for (int i = 0; i < 22; i++) begin
            v4 = (i < 20); a4 = 32'(i); b4 = 32'd1; s4 = 4'b0000;
            r4 = (i >= 2) ? 32'(i - 1) : 32'h0;
            tick();
            if (i >= 2) chk($sformatf("sat_pass_%0d", i), 32'(pass4), (i - 1 > 15) ? 15 : i - 1);
        end
        chk("sat_fail", 32'(fail4), 0);

        // Non-halting mismatches: count both, keep the first capture
        v4 = 1; a4 = 2; b4 = 2; s4 = 4'b0000; r4 = 0;
        tick();
        a4 = 9; b4 = 4; s4 = 4'b1000;
        tick();
        v4 = 0; r4 = 32'd7;
        tick();
        chk("nh_fail1", 32'(fail4), 1);
        chk("nh_error", 32'(error4), 1);
        chk("nh_halted", 32'(halted4), 0);
        chk("nh_err_opsel", 32'(err_opsel4), 0);
        chk("nh_err_exp", err_exp4, 32'd4);
        chk("nh_err_act", err_act4, 32'd7);
        r4 = 32'd8;
        tick();
        chk("nh_fail2", 32'(fail4), 2);
        chk("nh_err_act_hold", err_act4, 32'd7);
        chk("nh_pass", 32'(pass4), 15);

        // Clear coinciding with a mismatch compare: clear wins
        v4 = 1; a4 = 3; b4 = 3; s4 = 4'b0000; r4 = 0;
        tick();
        v4 = 0;
        tick();
        c4 = 1; r4 = 32'h0;
        tick();
        c4 = 0;
        chk("cc_pass", 32'(pass4), 0);
        chk("cc_fail", 32'(fail4), 0);
        chk("cc_error", 32'(error4), 0);
        chk("cc_halted", 32'(halted4), 0);
        chk("cc_err_opsel", 32'(err_opsel4), 0);
        chk("cc_err_exp", err_exp4, 0);
        chk("cc_err_act", err_act4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
